// File: rtl/rr_pkg.sv
// ---------------------------------------------------------------------------
// rr_pkg -- shared definitions for the round-robin burst scheduler family.
//   NREQ_DEF : default number of requesters (power of two, 2..8)
//   LENW_DEF : default burst-length field width (burst = 1..2^LENW beats)
//   state_e  : scheduler FSM encoding (IDLE / BURST)
// ---------------------------------------------------------------------------
package rr_pkg;

  localparam int NREQ_DEF = 4;
  localparam int LENW_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/rr_burst_scheduler_if.sv
// ---------------------------------------------------------------------------
// rr_burst_scheduler_if -- requester / resource bundle of the burst scheduler.
//   req        : per-requester request, level-sensitive
//   req_len    : per-requester burst length minus one (slice i = requester i)
//   res_ready  : shared resource accepts a beat this cycle
//   grant      : one-hot owner of the resource (zero when idle)
//   grant_id   : binary index of the owner (zero when idle)
//   beat_valid : a beat from the owner is presented
//   last_beat  : current beat is the final one of the burst
//   busy       : scheduler is running a burst
// modport master = requester/resource side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface rr_burst_scheduler_if
  import rr_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LENW = LENW_DEF
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][LENW-1:0] req_len;
  logic                      res_ready;
  logic [NREQ-1:0]           grant;
  logic [IDW-1:0]            grant_id;
  logic                      beat_valid;
  logic                      last_beat;
  logic                      busy;

  modport master (
    output req, req_len, res_ready,
    input  grant, grant_id, beat_valid, last_beat, busy
  );

  modport slave (
    input  req, req_len, res_ready,
    output grant, grant_id, beat_valid, last_beat, busy
  );

endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick -- combinational rotating-priority picker.
// Searches req_i starting at (last_i+1) mod NREQ, wrapping through last_i
// itself, and returns the first set bit.
//   req_i  : request vector
//   last_i : index of the most recently served requester
//   gnt_o  : one-hot winner (zero if no request)
//   idx_o  : binary winner index (zero if no request)
//   any_o  : at least one request present
// ---------------------------------------------------------------------------
module rr_pick
  import rr_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    // NREQ is a power of two, so IDW-bit overflow is the modulo wrap;
    // k = NREQ lands back on last_i, giving it lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_i + IDW'(k);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/rr_burst_scheduler.sv
// ---------------------------------------------------------------------------
// rr_burst_scheduler -- round-robin arbiter that hands a shared resource to
// one requester for a whole burst of (req_len+1) beats.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_burst_scheduler_if.slave (req/req_len/res_ready in,
//           grant/grant_id/beat_valid/last_beat/busy out)
// Only state, grant, grant_id, beat counter and last-served index are
// registered; beat_valid/last_beat/busy are decoded from state and counter.
// ---------------------------------------------------------------------------
module rr_burst_scheduler
  import rr_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LENW = LENW_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_burst_scheduler_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  gid_q,   gid_d;
  logic [IDW-1:0]  last_q,  last_d;
  logic [LENW-1:0] cnt_q,   cnt_d;

  logic [IDW-1:0]  pick_last;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            xfer;
  logic            done;

  assign xfer = (state_q == ST_BURST) && bus.res_ready;
  assign done = xfer && (cnt_q == '0);

  // A new winner out of BURST is only used on the completion edge, where
  // the current owner becomes "last" -- feed it straight in for the
  // zero-bubble hand-over instead of waiting for last_q to update.
  assign pick_last = (state_q == ST_BURST) ? gid_q : last_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (bus.req),
    .last_i (pick_last),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IDW'(NREQ - 1);   // requester 0 first after reset
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BURST;
          grant_d = pick_gnt;
          gid_d   = pick_idx;
          cnt_d   = bus.req_len[pick_idx];
        end
      end
      ST_BURST: begin
        if (done) begin
          last_d = gid_q;
          if (pick_any) begin
            grant_d = pick_gnt;
            gid_d   = pick_idx;
            cnt_d   = bus.req_len[pick_idx];
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            gid_d   = '0;
            cnt_d   = '0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q - LENW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.grant      = grant_q;
  assign bus.grant_id   = gid_q;
  assign bus.beat_valid = (state_q == ST_BURST);
  assign bus.busy       = (state_q == ST_BURST);
  assign bus.last_beat  = (state_q == ST_BURST) && (cnt_q == '0);

endmodule
